fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of decode.
- Owns the fetch PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles control-flow redirects (PCsrc/PCTarget from execute) by flushing buffered and in-flight fetches.

Parameters:
ADDRESS_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction width
DEPTH, 2, FIFO entries; power of two, >= 2
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
PCsrc  in  1  redirect request from execute
PCTarget  in  ADDRESS_WIDTH  redirect target
imem_req  out  1  fetch request
imem_addr  out  ADDRESS_WIDTH  fetch address, word-aligned
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  DATA_WIDTH  read data
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode accepts head
instr  out  DATA_WIDTH  head instruction
PC  out  ADDRESS_WIDTH  address of head instruction
PCPlus4  out  ADDRESS_WIDTH  PC + 4, wraps mod 2^ADDRESS_WIDTH

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; state = REQ; FIFO empty.
  - instr_valid = 0, instr/PC/PCPlus4 = 0, imem_req = 0.
- A memory transfer occurs only on a cycle with imem_req && imem_gnt. imem_req and imem_addr may change in any cycle without a grant. At most one request is outstanding.
- States:
  - REQ: imem_req = 1 iff FIFO count < DEPTH, where count is the registered count (a same-cycle pop does not count). imem_addr = fetch_pc. On gnt: fetch_pc += 4, go to WAIT.
  - WAIT: imem_req = 0. On rvalid: push {fetch address, imem_rdata}, go to REQ.
  - DROP: imem_req = 0. On rvalid: discard data, go to REQ.
- The credit rule (request only when count < DEPTH with one outstanding) guarantees a push never hits a full FIFO. A push and a pop in the same cycle are both legal.
- Decode side:
  - instr_valid = (count != 0). Head fields are read from registered storage.
  - Pop on instr_valid && instr_ready. Head fields must stay stable while valid && !ready.
- Redirect (PCsrc = 1) has highest priority:
  - fetch_pc <= {PCTarget[AW-1:2], 2'b00}.
  - FIFO flushed; instr_valid is 0 in the next cycle. Any same-cycle pop or push is void.
  - Next state:
    - REQ without gnt → REQ. The new address is presented the next cycle.
    - REQ with gnt → DROP. The granted old-address response is discarded, and fetch_pc is not incremented.
    - WAIT without rvalid → DROP.
    - WAIT with rvalid → REQ. Data dropped.
    - DROP without rvalid → DROP (new target kept).
    - DROP with rvalid → REQ.
- Latency: empty FIFO, gnt in cycle t, rvalid in cycle t+k → instr_valid in cycle t+k+1. Next request no earlier than t+k+1.
- Stored-PC arithmetic is modulo 2^ADDRESS_WIDTH, and fetch_pc wraps from all-ones-aligned to 0.
- Assertion of rst mid-transaction aborts it. An rvalid arriving after reset release while in REQ is ignored.
- An rvalid in REQ state is a protocol error: ignored, with a simulation assertion.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, DROP}
  - INSTR_BYTES = 4
  - fetch_entry_t struct {pc, instr}
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH parameter, push/pop/flush, count, and head outputs. Flush overrides push and pop.
- The top holds the FSM, fetch_pc and redirect logic.

Test Plan:
1. Reset: hold rst=1 mid-run → imem_req=0, instr_valid=0 immediately. Release → imem_req=1, imem_addr=0x0 the next cycle.
2. Streaming: gnt=1, rvalid one cycle after gnt with rdata=addr^0xA5A5_0000, ready=1 → instructions at PC 0x0, 0x4, 0x8 in order, PCPlus4 = 0x4, 0x8, 0xC, with data matching.
3. Backpressure: ready=0 → after 2 pushes (PC 0x0, 0x4), imem_req stays 0 and head stays 0x0. Set ready=1 → 0x0, 0x4 pop, and fetch of 0x8 resumes.
4. Redirect in WAIT: grant at 0x8, PCsrc=1 with PCTarget=0x103 the next cycle, rvalid later with 0xDEADBEEF → no push. Next imem_addr=0x100, first decoded PC=0x100.
5. Redirect coincident with gnt and with rvalid: each case → old data never appears on instr; FIFO empty; next request 0x200.
6. Wrap: RESET_PC=0xFFFF_FFFC → first PC=0xFFFF_FFFC, PCPlus4=0x0, second fetch address=0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states and the
// buffered {pc, instr} record.
package fetch_pkg;

    localparam int FETCH_AW    = 32;
    localparam int FETCH_DW    = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_DW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} records; flush empties it
// and overrides any push or pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  entry_t                       wr_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output entry_t                       head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one outstanding imem read at a
// time, buffers responses for decode and flushes everything on a redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DEPTH         = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PCsrc,
    input  logic [ADDRESS_WIDTH-1:0] PCTarget,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } q_entry_t;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [AW-1:0]   fetch_pc;
    logic [AW-1:0]   fetch_pc_nxt;
    logic [AW-1:0]   req_pc;
    logic [AW-1:0]   redirect_pc;
    logic            transfer;
    logic            push;
    logic            pop;
    logic [CW-1:0]   fifo_count;
    q_entry_t        wr_entry;
    q_entry_t        head;

    // Credit rule: with at most one read in flight, requesting only while the
    // registered count has room guarantees the response always fits.
    assign imem_req    = (state == REQ) && (fifo_count != CW'(DEPTH)) && !rst;
    assign imem_addr   = fetch_pc;
    assign transfer    = imem_req && imem_gnt;
    assign redirect_pc = PCTarget & ~AW'(INSTR_BYTES - 1);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        unique case (state)
            REQ: begin
                if (transfer) state_nxt = PCsrc ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = REQ;
                    push      = !PCsrc;
                end else if (PCsrc) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
        // A redirect wins over the increment of a same-cycle grant.
        if (PCsrc)         fetch_pc_nxt = redirect_pc;
        else if (transfer) fetch_pc_nxt = fetch_pc + AW'(INSTR_BYTES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) req_pc <= fetch_pc;
    end

    assign wr_entry = '{pc: req_pc, instr: imem_rdata};
    assign pop      = instr_valid && instr_ready;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (q_entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (PCsrc),
        .wr_entry (wr_entry),
        .count    (fifo_count),
        .head     (head)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? head.instr : '0;
    assign PC          = instr_valid ? head.pc : '0;
    assign PCPlus4     = instr_valid ? head.pc + AW'(INSTR_BYTES) : '0;

    a_no_rvalid_in_req: assert property (
        @(posedge clk) disable iff (rst) !(state == REQ && imem_rvalid)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle table, directed redirect/wrap sequences and a
// randomized run against an in-order fetch-stream reference model.
module tb_fetch_queue;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] pc_target = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;

    logic        w_gnt = 1'b0;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_queue u_dut (
        .clk(clk), .rst(rst), .PCsrc(pcsrc), .PCTarget(pc_target),
        .imem_req(req), .imem_addr(addr), .imem_gnt(gnt),
        .imem_rvalid(rvalid), .imem_rdata(rdata),
        .instr_valid(valid), .instr_ready(ready), .instr(instr),
        .PC(pc), .PCPlus4(pc4)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .PCsrc(1'b0), .PCTarget(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr_ready(1'b0), .instr(w_instr),
        .PC(w_pc), .PCPlus4(w_pc4)
    );

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rvalid;
        logic        ready;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_p4;
    } vec_t;

    vec_t tq[$];

    function automatic vec_t v(logic r, logic g, logic rv, logic rdy, logic [31:0] rd,
                               logic er, logic [31:0] ea, logic ev,
                               logic [31:0] ep, logic [31:0] ei, logic [31:0] e4);
        vec_t t;
        t = '{r, g, rv, rdy, rd, er, ea, ev, ep, ei, e4};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, got, exp);
        end
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pcsrc = 0; pc_target = '0; gnt = 0; rvalid = 0; rdata = '0;
        w_gnt = 0; w_rvalid = 0; w_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        adv();
        adv();
        rst = 0;
    endtask

    // Grant one request at the expected address, answer it the next cycle.
    task automatic fetch_one(input logic [31:0] a);
        gnt = 1;
        look();
        chk("fetch_req", req, 1);
        chk("fetch_addr", addr, a);
        adv();
        gnt = 0; rvalid = 1; rdata = a ^ K;
        look();
        chk("fetch_req_wait", req, 0);
        adv();
        rvalid = 0;
    endtask

    logic        pend;
    logic [31:0] paddr;
    int unsigned lat;
    logic        had;
    logic [31:0] exp_pc;
    int          pops;

    initial begin
        #1 rst = 1;

        // Reset, streaming, mid-transaction reset, backpressure.
        tq.push_back(v(1,0,0,1,0,          0,0,   0,0,0,0));
        tq.push_back(v(0,1,0,1,0,          1,0,   0,0,0,0));
        tq.push_back(v(0,1,1,1,K,          0,0,   0,0,0,0));
        tq.push_back(v(0,1,0,1,0,          1,4,   1,0,K,4));
        tq.push_back(v(0,0,1,1,K^4,        0,0,   0,0,0,0));
        tq.push_back(v(0,1,0,1,0,          1,8,   1,4,K^4,8));
        tq.push_back(v(0,0,1,1,K^8,        0,0,   0,0,0,0));
        tq.push_back(v(0,0,0,1,0,          1,12,  1,8,K^8,12));
        tq.push_back(v(0,1,0,1,0,          1,12,  0,0,0,0));
        tq.push_back(v(1,0,0,1,0,          0,0,   0,0,0,0));
        tq.push_back(v(0,1,0,0,0,          1,0,   0,0,0,0));
        tq.push_back(v(0,0,1,0,K,          0,0,   0,0,0,0));
        tq.push_back(v(0,1,0,0,0,          1,4,   1,0,K,4));
        tq.push_back(v(0,0,1,0,K^4,        0,0,   1,0,K,4));
        tq.push_back(v(0,1,0,0,0,          0,0,   1,0,K,4));
        tq.push_back(v(0,1,0,0,0,          0,0,   1,0,K,4));
        tq.push_back(v(0,1,0,1,0,          0,0,   1,0,K,4));
        tq.push_back(v(0,1,0,1,0,          1,8,   1,4,K^4,8));
        tq.push_back(v(0,0,1,1,K^8,        0,0,   0,0,0,0));
        tq.push_back(v(0,0,0,1,0,          1,12,  1,8,K^8,12));

        for (int i = 0; i < tq.size(); i++) begin
            rst = tq[i].rst; gnt = tq[i].gnt; rvalid = tq[i].rvalid;
            ready = tq[i].ready; rdata = tq[i].rdata;
            look();
            chk($sformatf("tbl%0d_req", i), req, tq[i].exp_req);
            if (tq[i].exp_req) chk($sformatf("tbl%0d_addr", i), addr, tq[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), valid, tq[i].exp_valid);
            chk($sformatf("tbl%0d_pc", i), pc, tq[i].exp_pc);
            chk($sformatf("tbl%0d_instr", i), instr, tq[i].exp_instr);
            chk($sformatf("tbl%0d_pc4", i), pc4, tq[i].exp_p4);
            adv();
        end

        // Redirect while waiting on a response.
        do_reset();
        ready = 1;
        fetch_one(32'h0);
        fetch_one(32'h4);
        gnt = 1;
        look();
        chk("rdw_req8", req, 1);
        chk("rdw_addr8", addr, 32'h8);
        adv();
        gnt = 0; pcsrc = 1; pc_target = 32'h103;
        look();
        adv();
        pcsrc = 0;
        look();
        chk("rdw_drop_req", req, 0);
        chk("rdw_drop_valid", valid, 0);
        adv();
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        look();
        chk("rdw_stale_req", req, 0);
        chk("rdw_stale_valid", valid, 0);
        adv();
        rvalid = 0;
        fetch_one(32'h100);
        look();
        chk("rdw_valid", valid, 1);
        chk("rdw_pc", pc, 32'h100);
        chk("rdw_instr", instr, 32'h100 ^ K);
        adv();

        // Redirect coincident with a grant.
        do_reset();
        ready = 1; gnt = 1; pcsrc = 1; pc_target = 32'h200;
        look();
        chk("rdg_req", req, 1);
        chk("rdg_addr", addr, 32'h0);
        adv();
        gnt = 0; pcsrc = 0;
        look();
        chk("rdg_drop_req", req, 0);
        chk("rdg_drop_valid", valid, 0);
        adv();
        rvalid = 1; rdata = K;
        look();
        chk("rdg_stale_valid", valid, 0);
        adv();
        rvalid = 0;
        look();
        chk("rdg_next_valid", valid, 0);
        chk("rdg_next_req", req, 1);
        chk("rdg_next_addr", addr, 32'h200);
        adv();

        // Redirect coincident with a response while the FIFO holds an entry.
        do_reset();
        ready = 0;
        fetch_one(32'h0);
        gnt = 1;
        look();
        chk("rdr_req", req, 1);
        chk("rdr_addr", addr, 32'h4);
        chk("rdr_head", pc, 32'h0);
        adv();
        gnt = 0; rvalid = 1; rdata = 32'h4 ^ K; pcsrc = 1; pc_target = 32'h200;
        look();
        adv();
        rvalid = 0; pcsrc = 0;
        look();
        chk("rdr_flush_valid", valid, 0);
        chk("rdr_next_req", req, 1);
        chk("rdr_next_addr", addr, 32'h200);
        adv();

        // Wrap of the fetch PC at the top of the address space.
        do_reset();
        w_gnt = 1;
        look();
        chk("wrap_req", w_req, 1);
        chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
        adv();
        w_gnt = 0; w_rvalid = 1; w_rdata = 32'hFFFF_FFFC ^ K;
        look();
        chk("wrap_req_wait", w_req, 0);
        adv();
        w_rvalid = 0;
        look();
        chk("wrap_valid", w_valid, 1);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'h0);
        chk("wrap_instr", w_instr, 32'hFFFF_FFFC ^ K);
        chk("wrap_req2", w_req, 1);
        chk("wrap_addr2", w_addr, 32'h0);
        adv();

        // Randomized run: decode must see consecutive words from the last
        // redirect target (or 0 after reset), each carrying addr ^ K.
        do_reset();
        pend = 0; paddr = '0; lat = 0; exp_pc = 32'h0; pops = 0;
        for (int c = 0; c < 3000; c++) begin
            had = pend;
            rvalid = 0; rdata = '0;
            if (pend) begin
                if (lat == 0) begin
                    rvalid = 1; rdata = paddr ^ K; pend = 0;
                end else begin
                    lat--;
                end
            end
            gnt = ($urandom_range(2) != 0);
            ready = $urandom_range(1);
            pcsrc = ($urandom_range(15) == 0);
            pc_target = $urandom;
            look();
            if (had) chk("rnd_one_outstanding", req, 0);
            if (req) chk("rnd_addr_align", addr & 32'h3, 0);
            if (req && gnt) begin
                pend = 1; paddr = addr; lat = $urandom_range(2);
            end
            if (pcsrc) begin
                exp_pc = pc_target & ~32'h3;
            end else if (valid && ready) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_instr", instr, exp_pc ^ K);
                chk("rnd_pc4", pc4, exp_pc + 32'h4);
                exp_pc = exp_pc + 32'h4;
                pops++;
            end
            adv();
        end
        idle_inputs();
        chk("rnd_liveness", (pops > 100) ? 32'h1 : 32'h0, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule
